// File: rtl/rs_age_select.sv
// ALU reservation station: CDB wakeup, age-matrix oldest-ready select.
// Optional dispatch-time CDB bypass enabled by RS_DISP_BYPASS_EN.
module rs_age_select #(
  parameter int RS_SIZE = 16,
  parameter int XLEN    = 32,
  parameter int TAG_W   = 4,
  parameter int OP_W    = 5,
  parameter int CDB_NUM = 2,
  localparam int CNT_W  = $clog2(RS_SIZE + 1),
  localparam int IDX_W  = $clog2(RS_SIZE)
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic                     rdy_in,
  input  logic                     flush_in,
  input  logic                     disp_valid,
  output logic                     disp_full,
  input  logic [TAG_W-1:0]         disp_tag,
  input  logic [OP_W-1:0]          disp_op,
  input  logic [XLEN-1:0]          disp_vj,
  input  logic [XLEN-1:0]          disp_vk,
  input  logic                     disp_qj_busy,
  input  logic                     disp_qk_busy,
  input  logic [TAG_W-1:0]         disp_qj,
  input  logic [TAG_W-1:0]         disp_qk,
  input  logic [XLEN-1:0]          disp_imm,
  input  logic [XLEN-1:0]          disp_pc,
  input  logic [CDB_NUM-1:0]       cdb_valid,
  input  logic [CDB_NUM*TAG_W-1:0] cdb_tag,
  input  logic [CDB_NUM*XLEN-1:0]  cdb_value,
  output logic                     iss_valid,
  input  logic                     iss_ready,
  output logic [TAG_W-1:0]         iss_tag,
  output logic [OP_W-1:0]          iss_op,
  output logic [XLEN-1:0]          iss_vj,
  output logic [XLEN-1:0]          iss_vk,
  output logic [XLEN-1:0]          iss_imm,
  output logic [XLEN-1:0]          iss_pc,
  output logic [CNT_W-1:0]         count
);

  logic [RS_SIZE-1:0] valid_q, valid_d;
  logic [RS_SIZE-1:0] qjb_q, qjb_d;
  logic [RS_SIZE-1:0] qkb_q, qkb_d;
  logic [TAG_W-1:0]   tag_q [RS_SIZE];
  logic [TAG_W-1:0]   tag_d [RS_SIZE];
  logic [OP_W-1:0]    op_q  [RS_SIZE];
  logic [OP_W-1:0]    op_d  [RS_SIZE];
  logic [XLEN-1:0]    vj_q  [RS_SIZE];
  logic [XLEN-1:0]    vj_d  [RS_SIZE];
  logic [XLEN-1:0]    vk_q  [RS_SIZE];
  logic [XLEN-1:0]    vk_d  [RS_SIZE];
  logic [TAG_W-1:0]   qj_q  [RS_SIZE];
  logic [TAG_W-1:0]   qj_d  [RS_SIZE];
  logic [TAG_W-1:0]   qk_q  [RS_SIZE];
  logic [TAG_W-1:0]   qk_d  [RS_SIZE];
  logic [XLEN-1:0]    imm_q [RS_SIZE];
  logic [XLEN-1:0]    imm_d [RS_SIZE];
  logic [XLEN-1:0]    pc_q  [RS_SIZE];
  logic [XLEN-1:0]    pc_d  [RS_SIZE];
  // age_q[j][i] set means entry j is older than entry i
  logic [RS_SIZE-1:0] age_q [RS_SIZE];
  logic [RS_SIZE-1:0] age_d [RS_SIZE];
  logic [CNT_W-1:0]   count_q, count_d;

  logic [RS_SIZE-1:0] ready;
  logic [RS_SIZE-1:0] win;
  logic [IDX_W-1:0]   free_idx;
  logic               disp_fire;
  logic               iss_fire;

  assign count     = count_q;
  assign disp_full = (count_q == CNT_W'(RS_SIZE));
  assign ready     = valid_q & ~qjb_q & ~qkb_q;
  assign iss_valid = (|ready) & rdy_in & ~flush_in;
  assign iss_fire  = iss_valid & iss_ready;
  assign disp_fire = disp_valid & ~disp_full
                   & ~flush_in & rdy_in;

  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      win[i] = ready[i];
      for (int j = 0; j < RS_SIZE; j++) begin
        if (ready[j] && age_q[j][i]) win[i] = 1'b0;
      end
    end
  end

  always_comb begin
    free_idx = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!valid_q[i]) free_idx = IDX_W'(i);
    end
  end

  always_comb begin
    iss_tag = '0;
    iss_op  = '0;
    iss_vj  = '0;
    iss_vk  = '0;
    iss_imm = '0;
    iss_pc  = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (win[i]) begin
        iss_tag |= tag_q[i];
        iss_op  |= op_q[i];
        iss_vj  |= vj_q[i];
        iss_vk  |= vk_q[i];
        iss_imm |= imm_q[i];
        iss_pc  |= pc_q[i];
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    qjb_d   = qjb_q;
    qkb_d   = qkb_q;
    tag_d   = tag_q;
    op_d    = op_q;
    vj_d    = vj_q;
    vk_d    = vk_q;
    qj_d    = qj_q;
    qk_d    = qk_q;
    imm_d   = imm_q;
    pc_d    = pc_q;
    age_d   = age_q;
    count_d = count_q;
    if (rdy_in && flush_in) begin
      valid_d = '0;
      count_d = '0;
      for (int i = 0; i < RS_SIZE; i++) age_d[i] = '0;
    end else if (rdy_in) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        for (int b = 0; b < CDB_NUM; b++) begin
          if (valid_q[i] && cdb_valid[b]) begin
            if (qjb_q[i] &&
                cdb_tag[b*TAG_W +: TAG_W] == qj_q[i]) begin
              vj_d[i]  = cdb_value[b*XLEN +: XLEN];
              qjb_d[i] = 1'b0;
            end
            if (qkb_q[i] &&
                cdb_tag[b*TAG_W +: TAG_W] == qk_q[i]) begin
              vk_d[i]  = cdb_value[b*XLEN +: XLEN];
              qkb_d[i] = 1'b0;
            end
          end
        end
      end
      if (iss_fire) valid_d = valid_d & ~win;
      if (disp_fire) begin
        valid_d[free_idx] = 1'b1;
        tag_d[free_idx]   = disp_tag;
        op_d[free_idx]    = disp_op;
        vj_d[free_idx]    = disp_vj;
        vk_d[free_idx]    = disp_vk;
        qj_d[free_idx]    = disp_qj;
        qk_d[free_idx]    = disp_qk;
        qjb_d[free_idx]   = disp_qj_busy;
        qkb_d[free_idx]   = disp_qk_busy;
        imm_d[free_idx]   = disp_imm;
        pc_d[free_idx]    = disp_pc;
`ifdef RS_DISP_BYPASS_EN
        for (int b = 0; b < CDB_NUM; b++) begin
          if (cdb_valid[b]) begin
            if (disp_qj_busy &&
                cdb_tag[b*TAG_W +: TAG_W] == disp_qj) begin
              vj_d[free_idx]  = cdb_value[b*XLEN +: XLEN];
              qjb_d[free_idx] = 1'b0;
            end
            if (disp_qk_busy &&
                cdb_tag[b*TAG_W +: TAG_W] == disp_qk) begin
              vk_d[free_idx]  = cdb_value[b*XLEN +: XLEN];
              qkb_d[free_idx] = 1'b0;
            end
          end
        end
`endif
        // new entry is younger than every live one; row and
        // column rewrite also clears stale bits of the old slot
        age_d[free_idx] = '0;
        for (int j = 0; j < RS_SIZE; j++) begin
          age_d[j][free_idx] = valid_q[j];
        end
      end
      count_d = count_q + CNT_W'(disp_fire)
                        - CNT_W'(iss_fire);
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      valid_q <= '0;
      qjb_q   <= '0;
      qkb_q   <= '0;
      count_q <= '0;
      for (int i = 0; i < RS_SIZE; i++) begin
        tag_q[i] <= '0;
        op_q[i]  <= '0;
        vj_q[i]  <= '0;
        vk_q[i]  <= '0;
        qj_q[i]  <= '0;
        qk_q[i]  <= '0;
        imm_q[i] <= '0;
        pc_q[i]  <= '0;
        age_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      qjb_q   <= qjb_d;
      qkb_q   <= qkb_d;
      count_q <= count_d;
      tag_q   <= tag_d;
      op_q    <= op_d;
      vj_q    <= vj_d;
      vk_q    <= vk_d;
      qj_q    <= qj_d;
      qk_q    <= qk_d;
      imm_q   <= imm_d;
      pc_q    <= pc_d;
      age_q   <= age_d;
    end
  end

endmodule
